// File: rtl/wb_order_buf_pkg.sv
// Shared definitions for the long-pipe writeback order buffer.
// WITF_* mirror the writeback instruction track FIFO geometry; the order
// buffer must be sized identically so that wb_en pops stay in lock-step.
package wb_order_buf_pkg;

   localparam int unsigned WITF_DEPTH  = 4;
   localparam int unsigned WITF_AWIDTH = 2;
   localparam int unsigned XLEN        = 64;
   localparam int unsigned RAW         = 5;

   // Pointer with an extra wrap flag above the index bits.
   typedef struct packed {
      logic                   wrap;
      logic [WITF_AWIDTH-1:0] idx;
   } witf_ptr_t;

endpackage : wb_order_buf_pkg

// File: rtl/wb_order_buf_ptr_ctr.sv
// wb_ptr_ctr: wrap-flag pointer counter.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   clr_i   synchronous clear (priority over inc_i)
//   inc_i   advance pointer by one
//   ptr_o   AW-bit index
//   wrap_o  wrap flag, toggles each time the index passes DEPTH-1
module wb_ptr_ctr #(
   parameter int unsigned AW = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [AW-1:0] ptr_o,
   output logic          wrap_o
);

   // Index and flag kept as one AW+1 counter: with DEPTH a power of two,
   // carry out of the index is exactly the flag toggle.
   logic [AW:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ptr_o  = cnt_q[AW-1:0];
   assign wrap_o = cnt_q[AW];

endmodule : wb_ptr_ctr

// File: rtl/wb_order_buf.sv
// wb_order_buf: in-order retirement buffer for long-pipe writeback.
// Entries are allocated at dispatch, completed out of order by tag, and
// retired strictly in allocation order to the single regfile write port.
// The ALU writeback has priority on that port.
// Ports:
//   clk, rst (async, active-low), flush
//   alloc_en/alloc_rd -> alloc_tag, full, empty       (dispatch side)
//   cmpl_valid/cmpl_tag/cmpl_data -> cmpl_ready       (long-pipe units)
//   alu_wen/alu_waddr/alu_wdata                       (ALU writeback)
//   rf_wen/rf_waddr/rf_wdata, wb_en                   (regfile, track FIFO pop)
module wb_order_buf
   import wb_order_buf_pkg::*;
#(
   parameter int unsigned DEPTH = wb_order_buf_pkg::WITF_DEPTH,
   parameter int unsigned AW    = wb_order_buf_pkg::WITF_AWIDTH,
   parameter int unsigned XLEN  = wb_order_buf_pkg::XLEN,
   parameter int unsigned RAW   = wb_order_buf_pkg::RAW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            alloc_en,
   input  logic [RAW-1:0]  alloc_rd,
   output logic [AW-1:0]   alloc_tag,
   output logic            full,
   output logic            empty,
   input  logic            cmpl_valid,
   input  logic [AW-1:0]   cmpl_tag,
   input  logic [XLEN-1:0] cmpl_data,
   output logic            cmpl_ready,
   input  logic            alu_wen,
   input  logic [RAW-1:0]  alu_waddr,
   input  logic [XLEN-1:0] alu_wdata,
   output logic            rf_wen,
   output logic [RAW-1:0]  rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_en
);

   logic [AW-1:0]    wptr, rptr;
   logic             wwrap, rwrap;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic [RAW-1:0]   rd_q   [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic             do_alloc, head_ok;

   wb_ptr_ctr #(.AW(AW)) u_wptr (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (flush),
      .inc_i  (do_alloc),
      .ptr_o  (wptr),
      .wrap_o (wwrap)
   );

   wb_ptr_ctr #(.AW(AW)) u_rptr (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (flush),
      .inc_i  (head_ok),
      .ptr_o  (rptr),
      .wrap_o (rwrap)
   );

   assign empty     = (rptr == wptr) && (rwrap == wwrap);
   assign full      = (rptr == wptr) && (rwrap != wwrap);
   assign alloc_tag = wptr;

   assign do_alloc   = alloc_en && !full && !flush;
   assign cmpl_ready = cmpl_valid && vld_q[cmpl_tag] && !done_q[cmpl_tag] && !flush;
   assign head_ok    = vld_q[rptr] && done_q[rptr] && !alu_wen && !flush;

   // Alloc (wptr) and retire (rptr) only share an index when full or empty,
   // where one of them is already blocked, so update order does not matter.
   always_comb begin
      vld_d  = vld_q;
      done_d = done_q;
      if (flush) begin
         vld_d  = '0;
         done_d = '0;
      end else begin
         if (do_alloc) begin
            vld_d[wptr]  = 1'b1;
            done_d[wptr] = 1'b0;
         end
         if (cmpl_ready) begin
            done_d[cmpl_tag] = 1'b1;
         end
         if (head_ok) begin
            vld_d[rptr]  = 1'b0;
            done_d[rptr] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q  <= '0;
         done_q <= '0;
      end else begin
         vld_q  <= vld_d;
         done_q <= done_d;
      end
   end

   // Payload storage, no reset: only read while the matching vld/done is set.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         rd_q[wptr] <= alloc_rd;
      end
      if (cmpl_ready) begin
         data_q[cmpl_tag] <= cmpl_data;
      end
   end

   always_comb begin
      rf_wen   = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      wb_en    = 1'b0;
      if (alu_wen) begin
         rf_wen   = 1'b1;
         rf_waddr = alu_waddr;
         rf_wdata = alu_wdata;
      end else if (head_ok) begin
         rf_wen   = 1'b1;
         rf_waddr = rd_q[rptr];
         rf_wdata = data_q[rptr];
         wb_en    = 1'b1;
      end
   end

endmodule : wb_order_buf

// File: tb/tb_wb_order_buf.sv
module tb_wb_order_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        alloc_en;
   logic [4:0]  alloc_rd;
   logic [1:0]  alloc_tag;
   logic        full, empty;
   logic        cmpl_valid;
   logic [1:0]  cmpl_tag;
   logic [63:0] cmpl_data;
   logic        cmpl_ready;
   logic        alu_wen;
   logic [4:0]  alu_waddr;
   logic [63:0] alu_wdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        wb_en;

   int unsigned checks = 0;
   int unsigned errors = 0;

   wb_order_buf #(.DEPTH(4), .AW(2), .XLEN(64), .RAW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .alloc_en   (alloc_en),
      .alloc_rd   (alloc_rd),
      .alloc_tag  (alloc_tag),
      .full       (full),
      .empty      (empty),
      .cmpl_valid (cmpl_valid),
      .cmpl_tag   (cmpl_tag),
      .cmpl_data  (cmpl_data),
      .cmpl_ready (cmpl_ready),
      .alu_wen    (alu_wen),
      .alu_waddr  (alu_waddr),
      .alu_wdata  (alu_wdata),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .wb_en      (wb_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // one more unit later, well away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; alloc_en = 1'b0; alloc_rd = '0;
      cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = '0;
      alu_wen = 1'b0; alu_waddr = '0; alu_wdata = '0;

      // ---- 1: reset state, single alloc/complete/retire ----
      #2;
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_tag", 64'(alloc_tag), 64'd0);
      chk("rst_rf_wen", 64'(rf_wen), 64'd0);
      chk("rst_wb_en", 64'(wb_en), 64'd0);
      chk("rst_cmpl_ready", 64'(cmpl_ready), 64'd0);
      #6 rst = 1'b1;
      tick();
      alloc_en = 1'b1; alloc_rd = 5'd5;
      settle();
      chk("t1_alloc_tag", 64'(alloc_tag), 64'd0);
      tick();
      alloc_en = 1'b0;
      cmpl_valid = 1'b1; cmpl_tag = 2'd0; cmpl_data = 64'hAA;
      settle();
      chk("t1_cmpl_ready", 64'(cmpl_ready), 64'd1);
      chk("t1_no_early_retire", 64'(wb_en), 64'd0);
      tick();
      cmpl_valid = 1'b0;
      settle();
      chk("t1_rf_wen", 64'(rf_wen), 64'd1);
      chk("t1_rf_waddr", 64'(rf_waddr), 64'd5);
      chk("t1_rf_wdata", rf_wdata, 64'hAA);
      chk("t1_wb_en", 64'(wb_en), 64'd1);
      tick();
      settle();
      chk("t1_empty_after", 64'(empty), 64'd1);
      chk("t1_wb_en_after", 64'(wb_en), 64'd0);

      // ---- 2: fill, refuse 5th alloc, out-of-order completion ----
      do_flush();
      for (int i = 0; i < 4; i++) begin
         alloc_en = 1'b1; alloc_rd = 5'(i + 1);
         settle();
         chk("t2_alloc_tag", 64'(alloc_tag), 64'(i));
         tick();
      end
      alloc_en = 1'b1; alloc_rd = 5'd9;
      settle();
      chk("t2_full", 64'(full), 64'd1);
      chk("t2_empty", 64'(empty), 64'd0);
      tick();
      alloc_en = 1'b0;
      settle();
      chk("t2_full_kept", 64'(full), 64'd1);
      chk("t2_tag_kept", 64'(alloc_tag), 64'd0);
      for (int t = 3; t >= 1; t--) begin
         cmpl_valid = 1'b1; cmpl_tag = 2'(t); cmpl_data = 64'h1000 + 64'(t);
         settle();
         chk("t2_cmpl_ready", 64'(cmpl_ready), 64'd1);
         chk("t2_no_retire", 64'(wb_en), 64'd0);
         tick();
      end
      cmpl_valid = 1'b1; cmpl_tag = 2'd0; cmpl_data = 64'h1000;
      settle();
      chk("t2_no_retire_head", 64'(wb_en), 64'd0);
      tick();
      cmpl_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t2_ret_wb_en", 64'(wb_en), 64'd1);
         chk("t2_ret_waddr", 64'(rf_waddr), 64'(i + 1));
         chk("t2_ret_wdata", rf_wdata, 64'h1000 + 64'(i));
         tick();
      end
      settle();
      chk("t2_empty_after", 64'(empty), 64'd1);
      chk("t2_idle_wb_en", 64'(wb_en), 64'd0);

      // ---- 3: ALU priority holds the head ----
      alloc_en = 1'b1; alloc_rd = 5'd6;
      tick();
      alloc_en = 1'b0;
      cmpl_valid = 1'b1; cmpl_tag = 2'd0; cmpl_data = 64'h66;
      tick();
      cmpl_valid = 1'b0;
      alu_wen = 1'b1; alu_waddr = 5'd7; alu_wdata = 64'h11;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("t3_alu_wen", 64'(rf_wen), 64'd1);
         chk("t3_alu_waddr", 64'(rf_waddr), 64'd7);
         chk("t3_alu_wdata", rf_wdata, 64'h11);
         chk("t3_alu_wb_en", 64'(wb_en), 64'd0);
         tick();
      end
      alu_wen = 1'b0;
      settle();
      chk("t3_head_wb_en", 64'(wb_en), 64'd1);
      chk("t3_head_waddr", 64'(rf_waddr), 64'd6);
      chk("t3_head_wdata", rf_wdata, 64'h66);
      tick();

      // ---- 4: wrap over six rounds ----
      do_flush();
      for (int r = 0; r < 6; r++) begin
         alloc_en = 1'b1; alloc_rd = 5'(10 + r);
         settle();
         chk("t4_tag", 64'(alloc_tag), 64'(r % 4));
         tick();
         alloc_en = 1'b0;
         settle();
         chk("t4_not_empty", 64'(empty), 64'd0);
         chk("t4_not_full", 64'(full), 64'd0);
         cmpl_valid = 1'b1; cmpl_tag = 2'(r % 4); cmpl_data = 64'h500 + 64'(r);
         tick();
         cmpl_valid = 1'b0;
         settle();
         chk("t4_wb_en", 64'(wb_en), 64'd1);
         chk("t4_waddr", 64'(rf_waddr), 64'(10 + r));
         chk("t4_wdata", rf_wdata, 64'h500 + 64'(r));
         tick();
         settle();
         chk("t4_empty", 64'(empty), 64'd1);
         chk("t4_full", 64'(full), 64'd0);
      end

      // ---- 5: refused completions (wptr now at tag 2) ----
      cmpl_valid = 1'b1; cmpl_tag = 2'd2; cmpl_data = 64'hDEAD;
      settle();
      chk("t5_unalloc_ready", 64'(cmpl_ready), 64'd0);
      cmpl_valid = 1'b0;
      alloc_en = 1'b1; alloc_rd = 5'd3;
      settle();
      chk("t5_tag", 64'(alloc_tag), 64'd2);
      tick();
      alloc_en = 1'b0;
      cmpl_valid = 1'b1; cmpl_tag = 2'd2; cmpl_data = 64'h77;
      settle();
      chk("t5_first_ready", 64'(cmpl_ready), 64'd1);
      tick();
      alu_wen = 1'b1; alu_waddr = 5'd1; alu_wdata = 64'h1;
      cmpl_data = 64'h88;
      settle();
      chk("t5_done_ready", 64'(cmpl_ready), 64'd0);
      chk("t5_hold_wb_en", 64'(wb_en), 64'd0);
      tick();
      alu_wen = 1'b0; cmpl_valid = 1'b0;
      settle();
      chk("t5_ret_wb_en", 64'(wb_en), 64'd1);
      chk("t5_ret_wdata", rf_wdata, 64'h77);
      tick();

      // ---- 6: flush with pending entries, then async reset ----
      for (int i = 0; i < 3; i++) begin
         alloc_en = 1'b1; alloc_rd = 5'(20 + i);
         tick();
      end
      alloc_en = 1'b0;
      cmpl_valid = 1'b1; cmpl_tag = 2'd3; cmpl_data = 64'h33;
      tick();
      flush = 1'b1; cmpl_tag = 2'd1; cmpl_data = 64'h44;
      settle();
      chk("t6_flush_wb_en", 64'(wb_en), 64'd0);
      chk("t6_flush_rf_wen", 64'(rf_wen), 64'd0);
      chk("t6_flush_cmpl_ready", 64'(cmpl_ready), 64'd0);
      tick();
      cmpl_valid = 1'b0;
      alu_wen = 1'b1; alu_waddr = 5'd9; alu_wdata = 64'h99;
      settle();
      chk("t6_flush_alu_wen", 64'(rf_wen), 64'd1);
      chk("t6_flush_alu_waddr", 64'(rf_waddr), 64'd9);
      tick();
      flush = 1'b0; alu_wen = 1'b0;
      settle();
      chk("t6_empty", 64'(empty), 64'd1);
      chk("t6_tag0", 64'(alloc_tag), 64'd0);
      chk("t6_no_wb_en", 64'(wb_en), 64'd0);
      alloc_en = 1'b1; alloc_rd = 5'd8;
      tick();
      alloc_en = 1'b0;
      cmpl_valid = 1'b1; cmpl_tag = 2'd0; cmpl_data = 64'h8;
      tick();
      cmpl_valid = 1'b0;
      settle();
      chk("t6_pre_rst_rf_wen", 64'(rf_wen), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_rf_wen", 64'(rf_wen), 64'd0);
      chk("t6_rst_empty", 64'(empty), 64'd1);
      chk("t6_rst_wb_en", 64'(wb_en), 64'd0);
      #2 rst = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_wb_order_buf

// File: doc/wb_order_buf.md
Name: wb_order_buf

Overview:
- Consumer end of the long-pipe writeback track. Dispatch allocates an entry in the same cycle it pushes into the writeback instruction track FIFO.
- Multi-cycle units (LSU, MUL/DIV) complete out of order, addressed by tag. The block retires entries strictly in allocation order to the single regfile write port.
- Each retirement emits wb_en, which pops the track FIFO in lock-step.
- Sits between the EXU long-pipe units and the regfile write port; the single-cycle ALU writeback shares that port and has priority.

Parameters:
- DEPTH, 4, number of entries. Must equal WITF_DEPTH, power of two, >=2.
- AW, 2, tag/pointer width, log2(DEPTH).
- XLEN, 64, result data width.
- RAW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries (trap/redirect).
- alloc_en  in  1  allocate entry. Driven identically to the track FIFO push (disp_en & !isRAW) for long-pipe instructions.
- alloc_rd  in  RAW  destination register of the allocated instruction.
- alloc_tag  out  AW  tag that will be assigned on alloc_en; equals wptr.
- full  out  1  all DEPTH entries allocated.
- empty  out  1  no entry allocated.
- cmpl_valid  in  1  long-pipe unit result valid.
- cmpl_tag  in  AW  tag of the result.
- cmpl_data  in  XLEN  result data.
- cmpl_ready  out  1  result accepted this cycle.
- alu_wen  in  1  ALU writeback request; highest priority.
- alu_waddr  in  RAW  ALU destination.
- alu_wdata  in  XLEN  ALU data.
- rf_wen  out  1  regfile write enable.
- rf_waddr  out  RAW  regfile write address.
- rf_wdata  out  XLEN  regfile write data.
- wb_en  out  1  one-cycle pop pulse to the track FIFO.

Behaviour:
- State:
  - wptr/rptr of AW bits, each with an extra wrap flag bit.
  - Per entry: vld, done, rd, data.
  - Reset (rst=0, async) clears pointers, flags, vld and done. rd/data are payload only and have no reset.
- Status:
  - empty = (rptr==wptr) & flags equal.
  - full = (rptr==wptr) & flags differ.
  - Both are registered-state derived, with no same-cycle bypass.
- Allocate:
  - When alloc_en & !full & !flush: entry[wptr] takes vld=1, done=0, rd=alloc_rd.
  - wptr increments; at DEPTH-1 it wraps to 0 and toggles its flag.
  - alloc_en while full is ignored, with no state change. Dispatch must stall on full.
- Complete:
  - cmpl_ready = cmpl_valid & vld[cmpl_tag] & !done[cmpl_tag] & !flush, combinational.
  - On cmpl_ready: done=1 and data=cmpl_data at the clock edge.
  - Completion to an invalid or already-done tag is refused (cmpl_ready=0), and the unit holds the request.
- Retire (combinational from registered state):
  - head_ok = vld[rptr] & done[rptr] & !alu_wen & !flush.
  - alu_wen=1: rf_wen=1, rf_waddr/rf_wdata = alu_waddr/alu_wdata, and the head waits.
  - head_ok=1: rf_wen=1, rf_waddr=rd[rptr], rf_wdata=data[rptr], wb_en=1. At the edge, vld[rptr]=0, done[rptr]=0, rptr increments with wrap/flag toggle.
  - Otherwise rf_wen=0, wb_en=0, and addr/data are don't-care but driven 0.
- Latency: the earliest retire is the cycle after cmpl_ready, since completion data is registered and there is no bypass.
- Ordering: a done non-head entry never retires before the head. At most one retire per cycle.
- Simultaneous events:
  - Alloc and retire in the same cycle are both performed; with DEPTH entries full, the alloc is still refused.
  - Alloc and complete in the same cycle target different tags by construction.
  - Completing the head in the same cycle it would retire is impossible, because retire needs done already set.
- rd=0: the entry retires normally with rf_waddr=0. The regfile ignores x0, and wb_en must still pulse to keep the track FIFO aligned.
- Flush:
  - At the edge, clears all vld/done and sets wptr=rptr=0 with flags 0.
  - In the flush cycle, no alloc, completion or retire takes effect. The ALU write still passes.
  - The track FIFO must be flushed in the same cycle.
- Outputs at reset with alu_wen=0: rf_wen=0, wb_en=0, cmpl_ready=0, full=0, empty=1, alloc_tag=0.

Decomposition:
- Shared defines header, alongside the existing ones:
  - WITF_DEPTH, WITF_AWIDTH and XLEN reused.
  - RegAddrBus and WITF_AddrBus bus macros reused.
- One natural sub-module: wb_ptr_ctr, a wrap-flag pointer with inc enable and sync clear.
  - Instantiated twice, for wptr and rptr.
  - Uses the codebase Reg cell with enable.

Test Plan:
1. Reset, then alloc rd=5 (tag 0), then complete tag0 data=0xAA: the next cycle shows rf_wen=1, rf_waddr=5, rf_wdata=0xAA, wb_en=1, and the cycle after that empty=1.
2. Alloc rd=1,2,3,4 into tags 0-3: full=1, and a fifth alloc is ignored (alloc_tag stays 0). Complete tags 3,2,1 first: no retire. Complete tag 0: retires rd 1,2,3,4 on four consecutive cycles.
3. Head done while alu_wen=1 for 2 cycles (waddr=7, wdata=0x11): rf shows ALU writes with wb_en=0, and the head retires on cycle 3.
4. Wrap: 6 alloc/complete/retire rounds with DEPTH=4. Tags go 0,1,2,3,0,1, and full/empty stay correct after the flag toggles.
5. Completion to an unallocated tag 2 (cmpl_valid=1) gives cmpl_ready=0. A second completion to a done tag is also refused.
6. Three entries allocated with one done, then flush: no wb_en, empty=1 next cycle, and the next alloc gets tag 0. Asserting rst mid-run gives rf_wen=0 and empty=1 immediately (async).
